// File: rtl/logic_pipe_pkg.sv
// Shared op encoding for the two-stage bitwise logic pipeline.
// Imported by logic_op and logic_pipe.
package logic_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOR  = 3'd0,
        OP_OR   = 3'd1,
        OP_AND  = 3'd2,
        OP_NAND = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_op.sv
// Purpose: combinational bitwise evaluation of one op on two operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline owns flow control.
module logic_op
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op)
            OP_NOR:  y = ~(a | b);
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/logic_pipe.sv
// Purpose: two-stage valid/ready pipeline computing a bitwise op, with zero/ones flags and a done counter.
// Latency: 2 cycles from input handshake to out_valid when empty; one result per cycle sustained.
// Backpressure: stalls propagate combinationally from out_ready to in_ready; holds up to 2 items.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    input  logic             clr_count,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op_e              op;
    } s1_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid;
    s1_t              s1_q;
    logic             s1_en;
    logic             s2_en;
    logic             in_hs;
    logic             out_hs;
    logic [WIDTH-1:0] y_d;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    // Gate with rst so upstream never sees ready while the pipe is held in reset.
    assign in_ready = s1_en && !rst;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_hs) begin
                s1_q <= '{a: a, b: b, op: op_e'(op)};
            end
        end
    end

    logic_op #(
        .WIDTH (WIDTH)
    ) u_logic_op (
        .a  (s1_q.a),
        .b  (s1_q.b),
        .op (s1_q.op),
        .y  (y_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            ones      <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y    <= y_d;
                zero <= ~|y_d;
                ones <= &y_d;
            end
        end
    end

    // Clear wins over a same-cycle completion; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (clr_count) begin
            op_count <= '0;
        end else if (out_hs && (op_count != CNT_MAX)) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: directed scenarios plus randomized valid/ready traffic.
module tb_logic_pipe;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             clr_count = 1'b0;
    logic [CNT_W-1:0] op_count;

    logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .ones      (ones),
        .clr_count (clr_count),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic       z;
        logic       o;
    } exp_t;

    exp_t sb[$];
    int   nchecks = 0;
    int   nerr    = 0;

    function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] w, input int o);
        case (o)
            0: return ~(x | w);
            1: return x | w;
            2: return x & w;
            3: return ~(x & w);
            4: return x ^ w;
            5: return ~(x ^ w);
            6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] w, input logic [2:0] o);
        exp_t e;
        e.y = model(x, w, int'(o));
        e.z = (e.y == 8'h00);
        e.o = (e.y == 8'hFF);
        sb.push_back(e);
    endtask

    task automatic drive_cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                               input logic [2:0] iop, input logic ordy, input logic iclr,
                               output logic acc);
        @(posedge clk);
        #1;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op        = iop;
        out_ready = ordy;
        clr_count = iclr;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) push(ia, ib, iop);
    endtask

    // Monitor: pops the scoreboard on every output handshake and tracks the counter.
    int         exp_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_y = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            chk("op_count", 64'(op_count), 64'(exp_cnt));
            if (prev_stall) begin
                chk("hold_vld", 64'(out_valid), 64'd1);
                chk("hold_y", 64'(y), 64'(prev_y));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL unexpected_out: got y=%0h expected no output", y);
                end else begin
                    e = sb.pop_front();
                    chk("y", 64'(y), 64'(e.y));
                    chk("zero", 64'(zero), 64'(e.z));
                    chk("ones", 64'(ones), 64'(e.o));
                end
            end
            if (clr_count) exp_cnt = 0;
            else if (out_valid && out_ready && exp_cnt < CNT_SAT) exp_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       acc;
        logic [7:0] sa[3];
        logic [7:0] sbv[3];
        logic [2:0] so[3];
        logic [7:0] seq_y[8];
        logic [7:0] stall_y;

        seq_y = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h5A, 8'hA5};

        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_ones", 64'(ones), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single op, latency 2
        drive_cycle(1'b1, 8'h0F, 8'h33, 3'd0, 1'b1, 1'b0, acc);
        chk("lat_acc", 64'(acc), 64'd1);
        drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
        chk("lat_vld", 64'(out_valid), 64'd1);
        chk("lat_y", 64'(y), 64'hC0);
        chk("lat_zero", 64'(zero), 64'd0);
        chk("lat_ones", 64'(ones), 64'd0);
        drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
        chk("lat_count", 64'(op_count), 64'd1);
        chk("no_stale", 64'(out_valid), 64'd0);

        // All ops back-to-back
        for (int i = 0; i < 10; i++) begin
            drive_cycle(i < 8, 8'hA5, 8'h5A, 3'(i), 1'b1, 1'b0, acc);
            if (i >= 2) begin
                chk("b2b_vld", 64'(out_valid), 64'd1);
                chk("b2b_y", 64'(y), 64'(seq_y[i-2]));
            end
        end
        repeat (2) drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);

        // Stall with 3 offered inputs
        for (int k = 0; k < 3; k++) begin
            sa[k]  = 8'($urandom);
            sbv[k] = 8'($urandom);
            so[k]  = 3'($urandom_range(0, 7));
        end
        stall_y = model(sa[0], sbv[0], int'(so[0]));
        drive_cycle(1'b1, sa[0], sbv[0], so[0], 1'b0, 1'b0, acc);
        chk("stall_acc0", 64'(acc), 64'd1);
        drive_cycle(1'b1, sa[1], sbv[1], so[1], 1'b0, 1'b0, acc);
        chk("stall_acc1", 64'(acc), 64'd1);
        drive_cycle(1'b1, sa[2], sbv[2], so[2], 1'b0, 1'b0, acc);
        chk("stall_full_rdy", 64'(in_ready), 64'd0);
        chk("stall_y", 64'(y), 64'(stall_y));
        drive_cycle(1'b1, sa[2], sbv[2], so[2], 1'b0, 1'b0, acc);
        chk("stall_full_rdy2", 64'(in_ready), 64'd0);
        drive_cycle(1'b1, sa[2], sbv[2], so[2], 1'b1, 1'b0, acc);
        chk("full_advance_acc", 64'(acc), 64'd1);
        repeat (4) drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
        chk("stall_drained", 64'(sb.size()), 64'd0);

        // Reset with 2 items in flight
        drive_cycle(1'b1, 8'h12, 8'h34, 3'd4, 1'b0, 1'b0, acc);
        drive_cycle(1'b1, 8'h56, 8'h78, 3'd1, 1'b0, 1'b0, acc);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_y", 64'(y), 64'd0);
        chk("arst_count", 64'(op_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 chk("arst_hold_rdy", 64'(in_ready), 64'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
            chk("arst_rel_rdy", 64'(in_ready), 64'd1);
            chk("arst_no_stale", 64'(out_valid), 64'd0);
        end

        // Counter saturation and clear-with-handshake
        for (int i = 0; i < 23; i++) begin
            drive_cycle(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b1,
                        i == 22, acc);
            if (i == 22) begin
                chk("sat_count", 64'(op_count), 64'(CNT_SAT));
                chk("clr_hs_vld", 64'(out_valid), 64'd1);
            end
        end
        drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
        chk("clr_count", 64'(op_count), 64'd0);
        repeat (2) drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            drive_cycle($urandom_range(0, 3) != 0, ra, rb, 3'($urandom_range(0, 7)),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, acc);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
        end
        chk("final_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
